iq_cic_decim: RTL and testbench



---
 rtl/iq_cic_decim_pkg.sv | 14 +
 rtl/iq_cic_decim_if.sv | 11 +
 rtl/iq_cic_decim_cic_chain.sv | 45 ++++
 rtl/iq_cic_decim.sv | 35 +++
 tb/tb_iq_cic_decim.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/iq_cic_decim_pkg.sv
// dsp_pkg: shared CIC helpers (sample type, log2 of a power of two, internal width W)
package dsp_pkg;
  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  function automatic int log2p(input int v);
    int l;
    l = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) == v) l = i;
    return l;
  endfunction
  function automatic int cic_w(input int dw, input int n, input int r);
    return dw + n * log2p(r);
  endfunction
endpackage

// File: rtl/iq_cic_decim_if.sv
// iq_cic_decim_if: I/Q stream bundle; master drives in_valid/i_in/q_in, slave drives out_valid/i_out/q_out
interface iq_cic_decim_if #(parameter int DW = 16);
  logic in_valid;
  logic signed [DW-1:0] i_in;
  logic signed [DW-1:0] q_in;
  logic out_valid;
  logic signed [DW-1:0] i_out;
  logic signed [DW-1:0] q_out;
  modport master(output in_valid, i_in, q_in, input out_valid, i_out, q_out);
  modport slave(input in_valid, i_in, q_in, output out_valid, i_out, q_out);
endinterface

// File: rtl/iq_cic_decim_cic_chain.sv
// cic_chain: one CIC rail (integrators, dec_reg, combs, gain-normalising shift); ports clk, reset, in_valid, strobe, strobe_q, x in, y out
module cic_chain import dsp_pkg::*; #(
  parameter int DW = 16,
  parameter int R = 4,
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 strobe,
  input  logic                 strobe_q,
  input  logic signed [DW-1:0] x,
  output logic signed [DW-1:0] y
);
  localparam int S = N * log2p(R);
  localparam int W = cic_w(DW, N, R);
  logic signed [W-1:0] integ [N];
  logic signed [W-1:0] dly [N];
  logic signed [W-1:0] c [N+1];
  logic signed [W-1:0] dec_reg;
  always_comb begin
    c[0] = dec_reg;
    for (int k = 0; k < N; k++) c[k+1] = c[k] - dly[k];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
        dly[k] <= '0;
      end
      dec_reg <= '0;
      y <= '0;
    end else begin
      if (in_valid) begin
        integ[0] <= integ[0] + W'(x);
        for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
      end
      if (strobe) dec_reg <= integ[N-1];
      if (strobe_q) begin
        for (int k = 0; k < N; k++) dly[k] <= c[k];
        y <= c[N][W-1:S];
      end
    end
  end
endmodule

// File: rtl/iq_cic_decim.sv
// iq_cic_decim: decimate-by-R CIC for I/Q; ports clk, reset, bus (slave: in_valid/i_in/q_in in, out_valid/i_out/q_out out)
module iq_cic_decim import dsp_pkg::*; #(
  parameter int DW = 16,
  parameter int R = 4,
  parameter int N = 3
) (
  input logic           clk,
  input logic           reset,
  iq_cic_decim_if.slave bus
);
  localparam int P = log2p(R);
  logic [P-1:0] phase;
  logic strobe;
  logic strobe_q;
  assign strobe = bus.in_valid && phase == P'(R - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      strobe_q <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      phase <= phase + P'(bus.in_valid);
      strobe_q <= strobe;
      bus.out_valid <= strobe_q;
    end
  end
  cic_chain #(.DW(DW), .R(R), .N(N)) u_i (
    .clk(clk), .reset(reset), .in_valid(bus.in_valid), .strobe(strobe),
    .strobe_q(strobe_q), .x(bus.i_in), .y(bus.i_out)
  );
  cic_chain #(.DW(DW), .R(R), .N(N)) u_q (
    .clk(clk), .reset(reset), .in_valid(bus.in_valid), .strobe(strobe),
    .strobe_q(strobe_q), .x(bus.q_in), .y(bus.q_out)
  );
endmodule

// File: tb/tb_iq_cic_decim.sv
// tb_iq_cic_decim: self-checking bench with a boxcar-convolution reference model and directed vectors
module tb_iq_cic_decim;
  import dsp_pkg::*;
  localparam int DW = 16;
  localparam int R = 4;
  localparam int N = 3;
  localparam int L = N * (R - 1) + 1;
  localparam int S = N * log2p(R);
  logic clk = 1'b0;
  logic reset = 1'b1;
  iq_cic_decim_if #(.DW(DW)) bus();
  iq_cic_decim #(.DW(DW), .R(R), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    int due;
    longint i;
    longint q;
  } exp_t;
  exp_t eq[$];
  longint xi[$], xq[$], li[$], lq[$], lc[$];
  longint h[L];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rst_prev = 1'b0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // output m of a block-decimated CIC = boxcar^N convolution of the accepted samples,
  // taken N samples behind the block's last sample, divided by R^N with floor
  function automatic longint model(input longint x[$]);
    longint acc;
    int n;
    acc = 0;
    n = x.size();
    for (int k = 0; k < L; k++) if (n - N - k >= 1) acc += h[k] * x[n - N - k - 1];
    return acc >>> S;
  endfunction
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_prev) begin
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_i_out", longint'(bus.i_out), 0);
      chk("rst_q_out", longint'(bus.q_out), 0);
    end
    if (bus.out_valid) begin
      if (eq.size() == 0 || eq[0].due != cyc) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk("i_out", longint'(bus.i_out), eq[0].i);
        chk("q_out", longint'(bus.q_out), eq[0].q);
        void'(eq.pop_front());
      end
      li.push_back(longint'(bus.i_out));
      lq.push_back(longint'(bus.q_out));
      lc.push_back(longint'(cyc));
    end else if (eq.size() != 0 && eq[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_out_valid: got 0 expected 1 (cycle %0d)", cyc);
      void'(eq.pop_front());
    end
    rst_prev = reset;
    if (reset) begin
      xi.delete();
      xq.delete();
      eq.delete();
    end else if (bus.in_valid) begin
      xi.push_back(longint'(bus.i_in));
      xq.push_back(longint'(bus.q_in));
      if (xi.size() % R == 0) begin
        e.due = cyc + 2;
        e.i = model(xi);
        e.q = model(xq);
        eq.push_back(e);
      end
    end
    cyc++;
  end
  task automatic step(input logic v, input longint i, input longint q, input logic r);
    @(posedge clk);
    #1;
    reset = r;
    bus.in_valid = v;
    bus.i_in = DW'(i);
    bus.q_in = DW'(q);
  endtask
  task automatic clear_log();
    li.delete();
    lq.delete();
    lc.delete();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.i_in = '0;
    bus.q_in = '0;
    for (int k = 0; k < L; k++) h[k] = 0;
    h[0] = 1;
    for (int s = 0; s < N; s++)
      for (int k = L - 1; k >= 0; k--)
        for (int j = 1; j < R; j++) if (k - j >= 0) h[k] += h[k-j];
    repeat (5) step(1'b1, longint'($urandom), longint'($urandom), 1'b1);
    clear_log();
    repeat (24) step(1'b1, 1000, -1000, 1'b0);
    repeat (4) step(1'b0, 0, 0, 1'b0);
    chk("dc_count", li.size(), 6);
    if (li.size() == 6) begin
      chk("dc_i1", li[0], 15);
      chk("dc_q1", lq[0], -16);
      chk("dc_i2", li[1], 500);
      chk("dc_q2", lq[1], -500);
      chk("dc_i3", li[2], 984);
      chk("dc_q3", lq[2], -985);
      chk("dc_i4", li[3], 1000);
      chk("dc_q4", lq[3], -1000);
      chk("dc_i6", li[5], 1000);
      chk("dc_period", lc[5] - lc[4], 4);
    end
    step(1'b0, 0, 0, 1'b1);
    clear_log();
    repeat (24) begin
      step(1'b1, 1000, -1000, 1'b0);
      step(1'b0, 0, 0, 1'b0);
    end
    repeat (4) step(1'b0, 0, 0, 1'b0);
    chk("gap_count", li.size(), 6);
    if (li.size() == 6) begin
      chk("gap_i4", li[3], 1000);
      chk("gap_q5", lq[4], -1000);
      chk("gap_i6", li[5], 1000);
      chk("gap_period", lc[5] - lc[4], 8);
    end
    step(1'b0, 0, 0, 1'b1);
    clear_log();
    repeat (200) step(1'b1, 32767, -32768, 1'b0);
    repeat (4) step(1'b0, 0, 0, 1'b0);
    chk("fs_count", li.size(), 50);
    if (li.size() == 50) begin
      chk("fs_i_last", li[49], 32767);
      chk("fs_q_last", lq[49], -32768);
    end
    step(1'b0, 0, 0, 1'b1);
    clear_log();
    repeat (10) begin
      step(1'b1, 1000, 0, 1'b0);
      step(1'b1, 0, 0, 1'b0);
      step(1'b1, -1000, 0, 1'b0);
      step(1'b1, 0, 0, 1'b0);
    end
    repeat (4) step(1'b0, 0, 0, 1'b0);
    chk("null_count", li.size(), 10);
    if (li.size() == 10) begin
      chk("null_i_last", li[9], 0);
      chk("null_q_last", lq[9], 0);
    end
    step(1'b0, 0, 0, 1'b1);
    clear_log();
    repeat (22) step(1'b1, 500, -500, 1'b0);
    chk("pre_rst_i", li.size() > 0 ? li[li.size()-1] : -1, 500);
    step(1'b1, 500, -500, 1'b1);
    clear_log();
    repeat (20) step(1'b1, 500, -500, 1'b0);
    repeat (4) step(1'b0, 0, 0, 1'b0);
    chk("mid_count", li.size(), 5);
    if (li.size() == 5) begin
      chk("mid_i1", li[0], 7);
      chk("mid_i4", li[3], 500);
      chk("mid_q4", lq[3], -500);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
